// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 integer divider (DIV/DIVU responder).
//
// The ALU raises validIn with SrcA (dividend), SrcB (divisor) and sign while
// the unit is idle. The unit divides magnitudes over WIDTH steps, applies the
// sign fix-up, and returns quotient on Lo and remainder on Hi with a one-cycle
// validOut pulse. Division truncates toward zero; the remainder takes the
// dividend's sign. A zero divisor returns Hi = SrcA, Lo = all ones.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset; aborts any operation in flight
//   validIn   request, sampled only in IDLE
//   sign      1 = signed (DIV), 0 = unsigned (DIVU)
//   SrcA      dividend
//   SrcB      divisor
//   validOut  one-cycle result pulse (registered)
//   Hi        remainder (registered, held)
//   Lo        quotient (registered, held)
//   busy      high while iterating or fixing up signs (registered)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             vout_q, vout_d;
    logic             busy_q, busy_d;

    // Operand magnitudes: negate only signed operands with the msb set.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign a_neg  = sign & SrcA[WIDTH-1];
    assign b_neg  = sign & SrcB[WIDTH-1];
    assign abs_a  = a_neg ? -SrcA : SrcA;
    assign abs_b  = b_neg ? -SrcB : SrcB;
    assign b_zero = (SrcB == '0);

    // One restoring step. The shifted remainder can reach 2*divisor-1, so the
    // trial subtract is done one bit wider and its msb is the borrow.
    logic [WIDTH:0] shl, trial;

    assign shl   = {rem_q, quo_q[WIDTH-1]};
    assign trial = shl - {1'b0, dvs_q};

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            vout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            vout_q  <= vout_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (validIn) state_d = b_zero ? DONE : BUSY;
            BUSY:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flags are registered, decoded from the state being entered.
    always_comb begin
        vout_d = (state_d == DONE);
        busy_d = (state_d == BUSY) || (state_d == FIXUP);
    end

    // Datapath next-state.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        unique case (state_q)
            IDLE: begin
                if (validIn) begin
                    qneg_d = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    rneg_d = a_neg;
                    dvs_d  = abs_b;
                    quo_d  = abs_a;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (b_zero) begin
                        // Divide by zero answers immediately, sign ignored.
                        hi_d = SrcA;
                        lo_d = '1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shl[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            FIXUP: begin
                lo_d = qneg_q ? -quo_q : quo_q;
                hi_d = rneg_q ? -rem_q : rem_q;
            end
            default: ;
        endcase
    end

    assign validOut = vout_q;
    assign busy     = busy_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule
